// File: rtl/xc_mask_rng_arb_pkg.sv
// Shared definitions for the masking-randomness arbiter: requester indices,
// LFSR feedback taps, the single-step LFSR function and the arbiter FSM states.
// Pure declarations; no latency or backpressure of its own.
package xc_mask_pkg;

  // Requester indices into req/gnt.
  localparam int MREQ_A2B = 0;
  localparam int MREQ_B2A = 1;
  localparam int MREQ_ALU = 2;

  // Galois feedback taps for the 32-bit mask LFSR.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  // One Galois step: shift right, fold the taps in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/xc_mask_rng_arb_rr_pick.sv
// Round-robin one-hot picker: first set bit of req scanning circularly from ptr.
// Latency: purely combinational. Backpressure: none, gnt is zero when req is zero.
// Ports: req (N requests), ptr (highest-priority index), gnt (one-hot or zero), idx (granted index).
module xc_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  always_comb begin : scan
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < 2^PW < 2N, so one wrap subtraction is always enough.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[PW'(j)]) begin
        found          = 1'b1;
        gnt[PW'(j)]    = 1'b1;
        idx            = PW'(j);
      end
    end
  end

endmodule

// File: rtl/xc_mask_rng_arb.sv
// Masking-randomness arbiter: one LFSR word per grant, round-robin over the masked units, reseedable with warm-up.
// Latency: gnt/mask_data are combinational from req and state (0 cycles); reseed takes effect the next cycle.
// Backpressure: requests are level and held until granted; no grants while seeding or warming up (busy high).
// Ports: g_clk, g_resetn (async active-low), req/gnt (NREQ), mask_data (32), seed_valid/seed_data (32), busy.
module xc_mask_rng_arb
  import xc_mask_pkg::*;
#(
  parameter int          NREQ       = MREQ_ALU + 1,
  parameter logic [31:0] RESET_SEED = 32'h0000_0001,
  parameter int          WARMUP     = 4
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     mask_data,
  input  logic            seed_valid,
  input  logic [31:0]     seed_data,
  output logic            busy
);

  localparam int         PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  // With no warm-up the counter is never consulted, so park it at zero.
  localparam logic [3:0] WCNT_INIT = (WARMUP == 0) ? 4'd0 : 4'(WARMUP - 1);
  localparam arb_state_t ST_INIT   = (WARMUP == 0) ? ST_RUN : ST_WARM;

  logic [31:0]     r_lfsr,  w_lfsr_nxt;
  arb_state_t      r_state, w_state_nxt;
  logic [3:0]      r_wcnt,  w_wcnt_nxt;
  logic [PW-1:0]   r_ptr,   w_ptr_nxt;

  logic [NREQ-1:0] w_pick_gnt;
  logic [PW-1:0]   w_pick_idx;
  logic [31:0]     w_lfsr_step;

  xc_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .idx (w_pick_idx)
  );

  assign w_lfsr_step = lfsr_step(r_lfsr);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_lfsr  <= RESET_SEED;
      r_state <= ST_INIT;
      r_wcnt  <= WCNT_INIT;
      r_ptr   <= PW'(MREQ_A2B);
    end else begin
      r_lfsr  <= w_lfsr_nxt;
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    gnt         = '0;
    mask_data   = '0;
    busy        = (r_state == ST_WARM);
    w_lfsr_nxt  = r_lfsr;
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_ptr_nxt   = r_ptr;

    if (seed_valid) begin
      // Reseed wins over warm-up and grants; a zero seed would lock the LFSR at zero.
      w_lfsr_nxt  = (seed_data == 32'h0) ? RESET_SEED : seed_data;
      w_wcnt_nxt  = WCNT_INIT;
      w_state_nxt = ST_INIT;
    end else if (r_state == ST_WARM) begin
      w_lfsr_nxt = w_lfsr_step;
      w_wcnt_nxt = r_wcnt - 4'd1;
      if (r_wcnt == 4'd0) w_state_nxt = ST_RUN;
    end else if (|req) begin
      // Advance only on a grant so each issued word is used exactly once.
      gnt        = w_pick_gnt;
      mask_data  = r_lfsr;
      w_lfsr_nxt = w_lfsr_step;
      w_ptr_nxt  = (w_pick_idx == PW'(NREQ - 1)) ? PW'(0) : (w_pick_idx + PW'(1));
    end
  end

endmodule

// File: tb/tb_xc_mask_rng_arb.sv
module tb_xc_mask_rng_arb;

  logic        g_clk;
  logic        g_resetn;
  logic [2:0]  req,  gnt;
  logic [31:0] mask_data, seed_data;
  logic        seed_valid, busy;

  logic [2:0]  req0, gnt0;
  logic [31:0] mask0, seed_data0;
  logic        seed_valid0, busy0;

  int total = 0;
  int bad   = 0;

  // Reference model of the WARMUP=4 instance.
  logic [31:0] m_lfsr;
  logic        m_warm;
  int          m_wcnt;
  int          m_ptr;
  logic [31:0] exp_q[$];
  logic [31:0] last_word;

  xc_mask_rng_arb #(.NREQ(3), .RESET_SEED(32'h0000_0001), .WARMUP(4)) u_dut (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .req        (req),
    .gnt        (gnt),
    .mask_data  (mask_data),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .busy       (busy)
  );

  xc_mask_rng_arb #(.NREQ(3), .RESET_SEED(32'h0000_0001), .WARMUP(0)) u_dut0 (
    .g_clk      (g_clk),
    .g_resetn   (g_resetn),
    .req        (req0),
    .gnt        (gnt0),
    .mask_data  (mask0),
    .seed_valid (seed_valid0),
    .seed_data  (seed_data0),
    .busy       (busy0)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] tb_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ ({32{v[0]}} & 32'h8020_0003);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 32'h0000_0001;
    m_warm = 1'b1;
    m_wcnt = 3;
    m_ptr  = 0;
    exp_q.delete();
  endtask

  // One clock of the WARMUP=4 instance: drive at edge+1, check at edge+3, advance model after the edge.
  task automatic cyc(input logic [2:0] r, input logic sv, input logic [31:0] sd);
    logic [2:0]  e_gnt;
    logic        e_busy;
    logic [31:0] e_word;
    int          e_idx;
    req        = r;
    seed_valid = sv;
    seed_data  = sd;
    e_gnt  = 3'b000;
    e_idx  = -1;
    e_busy = m_warm;
    if (!sv && !m_warm) begin
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (m_ptr + k) % 3;
        if (e_idx < 0 && r[2'(j)]) e_idx = j;
      end
    end
    if (e_idx >= 0) begin
      e_gnt[2'(e_idx)] = 1'b1;
      exp_q.push_back(m_lfsr);
    end
    #2;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("busy", 32'(busy), 32'(e_busy));
    if (e_idx >= 0) begin
      e_word = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("mask_data", mask_data, e_word);
      last_word = mask_data;
    end else begin
      chk("mask_idle", mask_data, 32'h0);
    end
    @(posedge g_clk);
    #1;
    if (sv) begin
      m_lfsr = (sd == 32'h0) ? 32'h0000_0001 : sd;
      m_warm = 1'b1;
      m_wcnt = 3;
    end else if (m_warm) begin
      m_lfsr = tb_step(m_lfsr);
      if (m_wcnt == 0) m_warm = 1'b0;
      m_wcnt = m_wcnt - 1;
    end else if (e_idx >= 0) begin
      m_lfsr = tb_step(m_lfsr);
      m_ptr  = (e_idx + 1) % 3;
    end
  endtask

  initial begin
    g_resetn    = 1'b0;
    req         = 3'b001;
    seed_valid  = 1'b0;
    seed_data   = 32'h0;
    req0        = 3'b000;
    seed_valid0 = 1'b0;
    seed_data0  = 32'h0;
    last_word   = 32'h0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mask", mask_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst0_busy", 32'(busy0), 32'h0);
    chk("rst0_gnt", 32'(gnt0), 32'h0);
    g_resetn = 1'b1;
    model_reset();

    // Reset warm-up: four silent cycles, then the fifth grants a2b.
    repeat (4) cyc(3'b001, 1'b0, 32'h0);
    cyc(3'b001, 1'b0, 32'h0);
    chk("warm_first_word", last_word, 32'hB02C_0003);

    // Round-robin: walk pointer back to 0, then all three requesting.
    cyc(3'b010, 1'b0, 32'h0);
    cyc(3'b100, 1'b0, 32'h0);
    repeat (3) cyc(3'b111, 1'b0, 32'h0);
    cyc(3'b001, 1'b0, 32'h0);

    // Non-zero reseed during a request.
    cyc(3'b111, 1'b1, 32'hDEAD_BEEF);
    repeat (4) cyc(3'b000, 1'b0, 32'h0);
    repeat (3) cyc(3'b111, 1'b0, 32'h0);

    // Random traffic with occasional (sometimes zero) reseeds.
    for (int n = 0; n < 10000; n++) begin
      logic [2:0]  r;
      logic        sv;
      logic [31:0] sd;
      r  = 3'($urandom_range(0, 7));
      sv = ($urandom_range(0, 499) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc(r, sv, sd);
    end
    while (m_warm) cyc(3'b000, 1'b0, 32'h0);

    // Zero seed falls back to RESET_SEED and re-runs the warm-up.
    cyc(3'b001, 1'b1, 32'h0);
    repeat (4) cyc(3'b001, 1'b0, 32'h0);
    cyc(3'b001, 1'b0, 32'h0);
    chk("zero_seed_word", last_word, 32'hB02C_0003);

    // Mid-run reset while granting.
    cyc(3'b001, 1'b0, 32'h0);
    req = 3'b001;
    #2;
    chk("pre_rst_gnt", 32'(gnt), 32'h1);
    g_resetn = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_mask", mask_data, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h1);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    model_reset();
    repeat (4) cyc(3'b001, 1'b0, 32'h0);
    cyc(3'b001, 1'b0, 32'h0);
    chk("post_rst_word", last_word, 32'hB02C_0003);

    // WARMUP=0 instance: direct grant, reseed, zero seed.
    req = 3'b000;
    req0 = 3'b001;
    #2;
    chk("w0_gnt_a", 32'(gnt0), 32'h1);
    chk("w0_mask_a", mask0, 32'h0000_0001);
    @(posedge g_clk);
    #1;
    seed_valid0 = 1'b1;
    seed_data0  = 32'h0000_0001;
    #2;
    chk("w0_seed_gnt", 32'(gnt0), 32'h0);
    chk("w0_seed_mask", mask0, 32'h0);
    @(posedge g_clk);
    #1;
    seed_valid0 = 1'b0;
    #2;
    chk("w0_gnt_b", 32'(gnt0), 32'h1);
    chk("w0_mask_b", mask0, 32'h0000_0001);
    chk("w0_busy", 32'(busy0), 32'h0);
    @(posedge g_clk);
    #3;
    chk("w0_mask_c", mask0, 32'h8020_0003);
    @(posedge g_clk);
    #1;
    seed_valid0 = 1'b1;
    seed_data0  = 32'h0;
    #2;
    chk("w0_zseed_gnt", 32'(gnt0), 32'h0);
    @(posedge g_clk);
    #1;
    seed_valid0 = 1'b0;
    #2;
    chk("w0_zseed_mask", mask0, 32'h0000_0001);
    @(posedge g_clk);
    #1;
    req0 = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
